// File: rtl/fifo4_ptr_ctrl_pkg.sv
// Shared constants for the 4-entry FIFO pointer controller.
package fifo4_ptr_ctrl_pkg;

    localparam int FIFO_AW    = 2;  // storage address width, matches the 2-bit comparator
    localparam int FIFO_PW    = 3;  // pointer width: wrap bit plus address
    localparam int FIFO_DEPTH = 4;  // entry count

    // Occupancy is the modular distance between the two wrap-extended pointers.
    function automatic logic [FIFO_PW-1:0] ptr_distance(
        input logic [FIFO_PW-1:0] wr_ptr,
        input logic [FIFO_PW-1:0] rd_ptr
    );
        return wr_ptr - rd_ptr;
    endfunction

endpackage

// File: rtl/fifo4_ptr_ctrl_comp2.sv
// 2-bit magnitude comparator: zx = (x > y), zy = (y > x), zeq = (x == y).
module fifo4_ptr_ctrl_comp2 (
    input  logic [1:0] x,
    input  logic [1:0] y,
    output logic       zx,
    output logic       zy,
    output logic       zeq
);

    logic eq_hi;
    logic eq_lo;

    // Bitwise equality first, then the MSB decides unless it ties.
    always_comb begin
        eq_hi = ~(x[1] ^ y[1]);
        eq_lo = ~(x[0] ^ y[0]);
        zeq   = eq_hi & eq_lo;
        zx    = (x[1] & ~y[1]) | (eq_hi & x[0] & ~y[0]);
        zy    = (y[1] & ~x[1]) | (eq_hi & y[0] & ~x[0]);
    end

endmodule

// File: rtl/fifo4_ptr_ctrl.sv
// 4-entry synchronous FIFO: register storage, wrap-extended pointers, status
// flags derived from the 2-bit address comparator plus the pointer wrap bits.
//
// Handshake: a write is accepted when wr_en is high and the FIFO is not full,
// or when it is full but a read is accepted in the same cycle. A read is
// accepted when rd_en is high and the FIFO is not empty; its data appears on
// rd_data with rd_valid one cycle later. Rejected requests are reported by a
// one-cycle overflow/underflow pulse on the following cycle and have no other
// effect.
module fifo4_ptr_ctrl
    import fifo4_ptr_ctrl_pkg::*;
#(
    parameter int DW    = 8,
    parameter int DEPTH = FIFO_DEPTH
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [DW-1:0] wr_data,
    input  logic          rd_en,
    output logic [DW-1:0] rd_data,
    output logic          rd_valid,
    output logic          full,
    output logic          empty,
    output logic [2:0]    count,
    output logic          overflow,
    output logic          underflow
);

    logic [DW-1:0]      mem [DEPTH];
    logic [FIFO_PW-1:0] wr_ptr;
    logic [FIFO_PW-1:0] rd_ptr;
    logic               addr_eq;
    logic               cmp_gt_unused;
    logic               cmp_lt_unused;
    logic               rd_acc;
    logic               wr_acc;

    // Only address equality is needed; the magnitude outputs are left idle.
    fifo4_ptr_ctrl_comp2 u_comp2 (
        .x   (wr_ptr[FIFO_AW-1:0]),
        .y   (rd_ptr[FIFO_AW-1:0]),
        .zx  (cmp_gt_unused),
        .zy  (cmp_lt_unused),
        .zeq (addr_eq)
    );

    // Status is purely a function of the registered pointers.
    always_comb begin
        empty  = addr_eq & (wr_ptr[FIFO_AW] == rd_ptr[FIFO_AW]);
        full   = addr_eq & (wr_ptr[FIFO_AW] != rd_ptr[FIFO_AW]);
        count  = ptr_distance(wr_ptr, rd_ptr);
        rd_acc = rd_en & ~empty;
        wr_acc = wr_en & (~full | rd_acc);
    end

    // Storage is not reset; writes in the reset cycle are dropped.
    always_ff @(posedge clk) begin
        if (!rst && wr_acc) begin
            mem[wr_ptr[FIFO_AW-1:0]] <= wr_data;
        end
    end

    // Pointers, registered read port and rejection pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            rd_data   <= '0;
            rd_valid  <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_acc) begin
                rd_ptr  <= rd_ptr + 1'b1;
                rd_data <= mem[rd_ptr[FIFO_AW-1:0]];
            end
            rd_valid  <= rd_acc;
            overflow  <= wr_en & full & ~rd_acc;
            underflow <= rd_en & empty;
        end
    end

endmodule

// File: tb/tb_fifo4_ptr_ctrl.sv
// Directed and randomized checks of fifo4_ptr_ctrl against a queue model.
module tb_fifo4_ptr_ctrl;

    logic       clk;
    logic       rst;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       rd_en;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       full;
    logic       empty;
    logic [2:0] count;
    logic       overflow;
    logic       underflow;

    int total;
    int bad;

    // Reference model state
    logic [7:0] exp_q[$];
    logic [7:0] exp_rd_data;
    logic       exp_rd_valid;
    logic       exp_ovf;
    logic       exp_unf;

    fifo4_ptr_ctrl #(.DW(8), .DEPTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (wr_en),
        .wr_data   (wr_data),
        .rd_en     (rd_en),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .full      (full),
        .empty     (empty),
        .count     (count),
        .overflow  (overflow),
        .underflow (underflow)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag);
        chk({tag, "_count"},     {5'd0, count},     8'(exp_q.size()));
        chk({tag, "_full"},      {7'd0, full},      {7'd0, exp_q.size() == 4});
        chk({tag, "_empty"},     {7'd0, empty},     {7'd0, exp_q.size() == 0});
        chk({tag, "_rd_valid"},  {7'd0, rd_valid},  {7'd0, exp_rd_valid});
        chk({tag, "_rd_data"},   rd_data,           exp_rd_data);
        chk({tag, "_overflow"},  {7'd0, overflow},  {7'd0, exp_ovf});
        chk({tag, "_underflow"}, {7'd0, underflow}, {7'd0, exp_unf});
    endtask

    // One clock of traffic; the model decides from occupancy before the edge.
    task automatic step(input string tag, input logic w, input logic [7:0] d, input logic r);
        bit was_full;
        bit was_empty;
        bit rd_ok;
        bit wr_ok;
        was_full  = (exp_q.size() == 4);
        was_empty = (exp_q.size() == 0);
        rd_ok     = r && !was_empty;
        wr_ok     = w && (!was_full || rd_ok);
        wr_en   = w;
        wr_data = d;
        rd_en   = r;
        @(posedge clk);
        #1;
        exp_rd_valid = rd_ok;
        if (rd_ok) exp_rd_data = exp_q.pop_front();
        if (wr_ok) exp_q.push_back(d);
        exp_ovf = w && was_full && !rd_ok;
        exp_unf = r && was_empty;
        wr_en = 1'b0;
        rd_en = 1'b0;
        chk_all(tag);
    endtask

    task automatic do_reset(input string tag, input logic w, input logic r);
        rst     = 1'b1;
        wr_en   = w;
        wr_data = 8'hEE;
        rd_en   = r;
        @(posedge clk);
        #1;
        rst   = 1'b0;
        wr_en = 1'b0;
        rd_en = 1'b0;
        exp_q.delete();
        exp_rd_data  = 8'h00;
        exp_rd_valid = 1'b0;
        exp_ovf      = 1'b0;
        exp_unf      = 1'b0;
        chk_all(tag);
    endtask

    initial begin
        total   = 0;
        bad     = 0;
        rst     = 1'b1;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        wr_data = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        do_reset("reset", 1'b0, 1'b0);

        // 1: fill
        step("t1_w1", 1'b1, 8'h11, 1'b0);
        chk("t1_empty_after_1", {7'd0, empty}, 8'd0);
        step("t1_w2", 1'b1, 8'h22, 1'b0);
        step("t1_w3", 1'b1, 8'h33, 1'b0);
        step("t1_w4", 1'b1, 8'h44, 1'b0);
        chk("t1_count4", {5'd0, count}, 8'd4);
        chk("t1_full4", {7'd0, full}, 8'd1);

        // 2: overflow
        step("t2_ovf", 1'b1, 8'h55, 1'b0);
        chk("t2_ovf_pulse", {7'd0, overflow}, 8'd1);
        step("t2_idle", 1'b0, 8'h00, 1'b0);
        chk("t2_ovf_clear", {7'd0, overflow}, 8'd0);

        // 3: simultaneous read+write while full
        step("t3_rw_full", 1'b1, 8'h66, 1'b1);
        chk("t3_rd_data", rd_data, 8'h11);
        chk("t3_count", {5'd0, count}, 8'd4);
        step("t3_d1", 1'b0, 8'h00, 1'b1);
        chk("t3_drain1", rd_data, 8'h22);
        step("t3_d2", 1'b0, 8'h00, 1'b1);
        chk("t3_drain2", rd_data, 8'h33);
        step("t3_d3", 1'b0, 8'h00, 1'b1);
        chk("t3_drain3", rd_data, 8'h44);
        step("t3_d4", 1'b0, 8'h00, 1'b1);
        chk("t3_drain4", rd_data, 8'h66);

        // 4: read+write while empty
        step("t4_rw_empty", 1'b1, 8'hA5, 1'b1);
        chk("t4_underflow", {7'd0, underflow}, 8'd1);
        chk("t4_count", {5'd0, count}, 8'd1);
        step("t4_rd", 1'b0, 8'h00, 1'b1);
        chk("t4_data", rd_data, 8'hA5);
        step("t4_hold", 1'b0, 8'h00, 1'b0);

        // 5: wrap-around, one in / one out
        for (int i = 0; i < 10; i++) begin
            step("t5_w", 1'b1, 8'(8'h30 + i), 1'b0);
            step("t5_r", 1'b0, 8'h00, 1'b1);
            chk("t5_order", rd_data, 8'(8'h30 + i));
        end

        // 6: reset mid-stream with a read pending
        step("t6_w1", 1'b1, 8'hC1, 1'b0);
        step("t6_w2", 1'b1, 8'hC2, 1'b0);
        step("t6_w3", 1'b1, 8'hC3, 1'b0);
        do_reset("t6_reset", 1'b0, 1'b1);
        step("t6_w_new", 1'b1, 8'hD7, 1'b0);
        step("t6_r_new", 1'b0, 8'h00, 1'b1);
        chk("t6_new_data", rd_data, 8'hD7);

        // Random traffic, with an occasional reset
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 99) == 0) begin
                do_reset("rnd_reset", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            end else begin
                step("rnd", 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
                     1'($urandom_range(0, 1)));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
